// File: rtl/hprb_source_pkg.sv
// Shared definitions for the probe source: field size defaults, on/off
// levels, the debounce default and the FSM state encoding.
package hprb_source_pkg;

  localparam int NS_ADDRESS_SIZE = 4;
  localparam int NS_DATA_SIZE    = 8;
  localparam int NS_REDUN_SIZE   = 4;
  localparam int NS_REQ_CKS      = 3;

  localparam logic NS_ON  = 1'b1;
  localparam logic NS_OFF = 1'b0;

  localparam logic [31:0] MSG_CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_LOAD = 3'd1,
    ST_REQ  = 3'd2,
    ST_REL  = 3'd3,
    ST_DONE = 3'd4
  } hprb_state_t;

endpackage

// File: rtl/hprb_source_if.sv
// Four-phase send channel: request plus message fields out, acknowledge back.
interface hprb_source_if
  import hprb_source_pkg::*;
#(
  parameter int ASZ = NS_ADDRESS_SIZE,
  parameter int DSZ = NS_DATA_SIZE,
  parameter int RSZ = NS_REDUN_SIZE
);

  logic           req_out;
  logic           ack_in;
  logic [ASZ-1:0] src;
  logic [ASZ-1:0] dst;
  logic [DSZ-1:0] dat;
  logic [RSZ-1:0] red;

  modport master (output req_out, src, dst, dat, red, input ack_in);
  modport slave  (input req_out, src, dst, dat, red, output ack_in);

endinterface

// File: rtl/hprb_source_calc_redun.sv
// Redundancy over a message: bits of {src, dst, dat} (LSB = bit 0) are
// XOR-folded into RSZ columns, bit i landing in column i mod RSZ. The
// receiving sink recomputes the same fold.
module calc_redun #(
  parameter int ASZ = 4,
  parameter int DSZ = 8,
  parameter int RSZ = 4
) (
  input  logic [ASZ-1:0] src,
  input  logic [ASZ-1:0] dst,
  input  logic [DSZ-1:0] dat,
  output logic [RSZ-1:0] red
);

  localparam int W = 2*ASZ + DSZ;

  logic [W-1:0] word;

  assign word = {src, dst, dat};

  // fold the message word into RSZ parity columns
  always_comb begin
    red = '0;
    for (int i = 0; i < W; i++) begin
      red[i % RSZ] = red[i % RSZ] ^ word[i];
    end
  end

endmodule

// File: rtl/hprb_source.sv
// Probe message source: sends an incrementing data sequence over a
// four-phase req/ack channel, optionally stopping after NUM_MSGS messages.
// Optional feature macro: HPRB_SOURCE_ACK_DEBOUNCE_EN (ack must be stable
// for ACK_CKS cycles before it is believed). Default build registers the
// ack once.
//
// state | meaning
// INIT  | one cycle after reset release, raises gch_ready
// LOAD  | latch src/dst/dat/red for the next message
// REQ   | req high, waiting for qualified ack high
// REL   | req low, waiting for qualified ack low, then advance counters
// DONE  | NUM_MSGS sent, terminal until reset
module hprb_source
  import hprb_source_pkg::*;
#(
  parameter int MY_LOCAL_ADDR = 0,
  parameter int PRB_DST_ADDR  = 0,
  parameter int ASZ           = NS_ADDRESS_SIZE,
  parameter int DSZ           = NS_DATA_SIZE,
  parameter int RSZ           = NS_REDUN_SIZE,
  parameter int FIRST_DAT     = 0,
  parameter int NUM_MSGS      = 0,
  parameter int ACK_CKS       = NS_REQ_CKS
) (
  input  logic          gch_clk,
  input  logic          gch_reset,
  output logic          gch_ready,
  output logic          done,
  hprb_source_if.master snd0
);

`ifdef HPRB_SOURCE_ACK_DEBOUNCE_EN
  localparam bit DEBOUNCE_EN = 1'b1;
`else
  localparam bit DEBOUNCE_EN = 1'b0;
`endif

  // Without debounce the qualifier degenerates to a single register stage.
  localparam int QUAL_CKS = (DEBOUNCE_EN && ACK_CKS > 1) ? ACK_CKS : 1;
  localparam int CW       = $clog2(QUAL_CKS + 1);

  localparam logic [ASZ-1:0] SRC_ADDR  = ASZ'(MY_LOCAL_ADDR);
  localparam logic [ASZ-1:0] DST_ADDR  = ASZ'(PRB_DST_ADDR);
  localparam logic [DSZ-1:0] DAT_START = DSZ'(FIRST_DAT);
  localparam logic [31:0]    MSG_LIMIT = 32'(NUM_MSGS);

  hprb_state_t    state;
  logic           ack_q;
  logic [CW-1:0]  stab_cnt;
  logic [DSZ-1:0] dat_cnt;
  logic [31:0]    msg_cnt;
  logic [31:0]    msg_cnt_inc;
  logic [RSZ-1:0] red_next;

  calc_redun #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_calc_redun (
    .src (SRC_ADDR),
    .dst (DST_ADDR),
    .dat (dat_cnt),
    .red (red_next)
  );

  assign msg_cnt_inc = msg_cnt + 32'd1;

  // qualify ack: adopt a new level only after QUAL_CKS consecutive samples
  always_ff @(posedge gch_clk or negedge gch_reset) begin
    if (!gch_reset) begin
      ack_q    <= NS_OFF;
      stab_cnt <= '0;
    end else if (snd0.ack_in == ack_q) begin
      stab_cnt <= '0;
    end else if (stab_cnt == CW'(QUAL_CKS - 1)) begin
      ack_q    <= snd0.ack_in;
      stab_cnt <= '0;
    end else begin
      stab_cnt <= stab_cnt + 1'b1;
    end
  end

  // message sequencing FSM with registered channel outputs
  always_ff @(posedge gch_clk or negedge gch_reset) begin
    if (!gch_reset) begin
      state        <= ST_INIT;
      gch_ready    <= NS_OFF;
      done         <= NS_OFF;
      snd0.req_out <= NS_OFF;
      snd0.src     <= '0;
      snd0.dst     <= '0;
      snd0.dat     <= '0;
      snd0.red     <= '0;
      dat_cnt      <= DAT_START;
      msg_cnt      <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          gch_ready <= NS_ON;
          state     <= ST_LOAD;
        end
        ST_LOAD: begin
          snd0.src     <= SRC_ADDR;
          snd0.dst     <= DST_ADDR;
          snd0.dat     <= dat_cnt;
          snd0.red     <= red_next;
          snd0.req_out <= NS_ON;
          state        <= ST_REQ;
        end
        ST_REQ: begin
          if (ack_q) begin
            snd0.req_out <= NS_OFF;
            state        <= ST_REL;
          end
        end
        ST_REL: begin
          if (!ack_q) begin
            dat_cnt <= dat_cnt + 1'b1;
            if (msg_cnt != MSG_CNT_MAX) msg_cnt <= msg_cnt_inc;
            if (MSG_LIMIT != 32'd0 && msg_cnt_inc == MSG_LIMIT) begin
              done  <= NS_ON;
              state <= ST_DONE;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_DONE: begin
          snd0.req_out <= NS_OFF;
          done         <= NS_ON;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule
